// File: rtl/irq_ctrl.sv
// Interrupt controller: per-line edge/level pending latches, priority select to CP0 HWInt,
// in-service tracking until EOI. Optional one-level preemption under `IRQ_NEST_EN.

module irq_line (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic mode,
  input  logic w1c,
  input  logic ack_clr,
  output logic pending
);
  logic prev;

  // Edge lines latch until W1C or ack; a new edge in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev <= src;
      if (mode) pending <= (src & ~prev) | (pending & ~(w1c | ack_clr));
      else      pending <= src;
    end
  end
endmodule

module irq_ctrl #(
  parameter int N_IRQ = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             int_ack,
  output logic [5:0]       hw_int,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, SERVICE = 2'd2} state_t;

  state_t           state, state_n;
  logic [N_IRQ-1:0] enable, mode, pending, req_vec, w1c, ack_clr;
  logic [2:0]       top, isr_id;
  logic [5:0]       top_hot, hw_int_d;
  logic             has_req, eoi, ack_take, nest;
`ifdef IRQ_NEST_EN
  logic [2:0]       saved_id;
  logic             push, pop;
`endif

  wire unused_wdata = ^wdata[31:N_IRQ];

  assign req_vec = pending & enable;
  assign has_req = |req_vec;
  assign eoi     = we && (addr == 2'd3);
  assign w1c     = (we && addr == 2'd2) ? wdata[N_IRQ-1:0] : '0;
  assign ack_clr = ack_take ? (N_IRQ'(1) << top) : '0;
  assign top_hot = has_req ? (6'd1 << top) : 6'd0;
  assign busy    = (state == SERVICE);

  always_comb begin
    top = '0;
    for (int i = 0; i < N_IRQ; i++)
      if (req_vec[i]) top = 3'(i);
  end

  irq_line u_line [N_IRQ-1:0] (
    .clk(clk), .reset(reset), .src(irq_src), .mode(mode),
    .w1c(w1c), .ack_clr(ack_clr), .pending(pending)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (has_req) state_n = ACTIVE;
      ACTIVE:  if (int_ack) state_n = SERVICE;
               else if (!has_req) state_n = IDLE;
      SERVICE: if (eoi && !nest) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    hw_int_d = '0;
    ack_take = 1'b0;
`ifdef IRQ_NEST_EN
    push     = 1'b0;
    pop      = 1'b0;
`endif
    case (state)
      IDLE:   hw_int_d = top_hot;
      ACTIVE: if (int_ack) ack_take = has_req;
              else         hw_int_d = top_hot;
      SERVICE: begin
`ifdef IRQ_NEST_EN
        // EOI beats a coincident ack; only a strictly higher line may preempt.
        if (eoi) begin
          if (nest) pop = 1'b1;
          else      hw_int_d = top_hot;
        end else if (!nest && has_req && top > isr_id) begin
          if (int_ack) begin
            ack_take = 1'b1;
            push     = 1'b1;
          end else hw_int_d = top_hot;
        end
`else
        if (eoi) hw_int_d = top_hot;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= '0;
      mode   <= '0;
      isr_id <= '0;
      hw_int <= '0;
`ifdef IRQ_NEST_EN
      saved_id <= '0;
      nest     <= 1'b0;
`endif
    end else begin
      if (we && addr == 2'd0) enable <= wdata[N_IRQ-1:0];
      if (we && addr == 2'd1) mode   <= wdata[N_IRQ-1:0];
      hw_int <= hw_int_d;
      if (ack_take) isr_id <= top;
`ifdef IRQ_NEST_EN
      if (push) begin
        saved_id <= isr_id;
        nest     <= 1'b1;
      end
      if (pop) begin
        isr_id <= saved_id;
        nest   <= 1'b0;
      end
`endif
    end
  end

`ifndef IRQ_NEST_EN
  assign nest = 1'b0;
`endif

  always_comb begin
    case (addr)
      2'd0:    rdata = 32'(enable);
      2'd1:    rdata = 32'(mode);
      2'd2:    rdata = 32'(pending);
      default: rdata = {busy, 23'b0, nest, isr_id, 4'b0};
    endcase
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expectations queued as stimulus is applied, drained after
// the clock edge that should produce them. Nesting steps run when IRQ_NEST_EN is defined.

module tb_irq_ctrl;
  localparam int N_IRQ = 6;
  localparam int HW = 0, BSY = 1, RD = 2;

  logic             clk = 1'b0;
  logic             reset, we, int_ack, busy;
  logic [N_IRQ-1:0] irq_src;
  logic [1:0]       addr;
  logic [31:0]      wdata, rdata;
  logic [5:0]       hw_int;

  always #10 clk = ~clk;

  irq_ctrl #(.N_IRQ(N_IRQ)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .int_ack(int_ack), .hw_int(hw_int), .busy(busy)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [1:0]  a;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nerr = 0;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; wdata = '0;
  endtask

  task automatic exp_v(input string tag, input int sel, input logic [1:0] a, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.a = a; e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [31:0] obs;
    logic [1:0]  sa;
    sa = addr;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        HW:      obs = {26'b0, hw_int};
        BSY:     obs = {31'b0, busy};
        default: begin addr = e.a; #1; obs = rdata; end
      endcase
      ncmp++;
      assert (obs === e.val) else begin
        nerr++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
    addr = sa;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; int_ack = 1'b0; irq_src = '0;
    tick(2);
    reset = 1'b0;
    exp_v("rst_hw", HW, 0, 0); exp_v("rst_busy", BSY, 0, 0);
    exp_v("rst_en", RD, 0, 0); exp_v("rst_mode", RD, 1, 0);
    exp_v("rst_pend", RD, 2, 0); exp_v("rst_ctrl", RD, 3, 0);
    check_sb();

    // edge line 0: pending next cycle, hw_int one cycle after that
    wr(0, 32'h3F); wr(1, 32'h01);
    irq_src = 6'h01;
    exp_v("t1_pend", RD, 2, 32'h01); exp_v("t1_hw_lat", HW, 0, 0);
    tick(); check_sb();
    exp_v("t1_hw", HW, 0, 32'h01);
    tick(); check_sb();
    exp_v("eoi_active_hw", HW, 0, 32'h01); exp_v("eoi_active_busy", BSY, 0, 0);
    wr(3, 0); check_sb();
    irq_src = 6'h00;
    wr(2, 32'h01);
    exp_v("w1c_pend", RD, 2, 0); exp_v("w1c_hw", HW, 0, 0);
    tick(); check_sb();

    // lines 2 and 5 pending, ack takes 5
    wr(1, 32'h25);
    irq_src = 6'h24; tick();
    irq_src = 6'h00;
    exp_v("t2_hw5", HW, 0, 32'h20);
    tick(); check_sb();
    int_ack = 1'b1;
    exp_v("t2_svc_hw", HW, 0, 0); exp_v("t2_busy", BSY, 0, 1);
    exp_v("t2_ctrl", RD, 3, 32'h8000_0050); exp_v("t2_pend", RD, 2, 32'h04);
    tick(); int_ack = 1'b0; check_sb();
    exp_v("t2_eoi_hw", HW, 0, 32'h04); exp_v("t2_eoi_busy", BSY, 0, 0);
    wr(3, 0); check_sb();
    int_ack = 1'b1;
    exp_v("ack_idle_busy", BSY, 0, 0); exp_v("ack_idle_ctrl", RD, 3, 32'h50);
    tick(); check_sb();
    exp_v("t2b_busy", BSY, 0, 1); exp_v("t2b_ctrl", RD, 3, 32'h8000_0020); exp_v("t2b_pend", RD, 2, 0);
    tick(); int_ack = 1'b0; check_sb();
    exp_v("t2b_eoi_hw", HW, 0, 0); exp_v("t2b_eoi_busy", BSY, 0, 0);
    wr(3, 0); check_sb();

    // edge and W1C on line 1 together: set wins
    wr(1, 32'h27);
    irq_src = 6'h02;
    exp_v("t3_set_wins", RD, 2, 32'h02);
    wr(2, 32'h02); irq_src = 6'h00; check_sb();
    exp_v("t3_w1c", RD, 2, 0); exp_v("t3_hw", HW, 0, 32'h02);
    wr(2, 32'h02); check_sb();
    exp_v("t3_idle_hw", HW, 0, 0);
    tick(); check_sb();

    // level line 3 held through service and EOI
    irq_src = 6'h08; tick();
    exp_v("t4_hw", HW, 0, 32'h08);
    tick(); check_sb();
    int_ack = 1'b1;
    exp_v("t4_busy", BSY, 0, 1); exp_v("t4_svc_hw", HW, 0, 0); exp_v("t4_level_kept", RD, 2, 32'h08);
    tick(); int_ack = 1'b0; check_sb();
    exp_v("en_clr_busy", BSY, 0, 1); exp_v("en_clr_hw", HW, 0, 0);
    wr(0, 0); check_sb();
    wr(0, 32'h3F);
    int_ack = 1'b1;
    exp_v("eoi_wins_hw", HW, 0, 32'h08); exp_v("eoi_wins_busy", BSY, 0, 0);
    exp_v("eoi_wins_ctrl", RD, 3, 32'h30);
    wr(3, 0); int_ack = 1'b0; check_sb();

    // reset in SERVICE with PENDING=0x21
    irq_src = 6'h00; tick(2);
    irq_src = 6'h21; tick();
    irq_src = 6'h00; tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    irq_src = 6'h20;
    exp_v("t5_pend", RD, 2, 32'h21); exp_v("t5_busy", BSY, 0, 1);
    tick(); irq_src = 6'h00; check_sb();
    reset = 1'b1;
    exp_v("t5_en", RD, 0, 0); exp_v("t5_mode", RD, 1, 0); exp_v("t5_pend0", RD, 2, 0);
    exp_v("t5_ctrl", RD, 3, 0); exp_v("t5_hw", HW, 0, 0); exp_v("t5_busy0", BSY, 0, 0);
    tick(); check_sb();
    reset = 1'b0;

`ifdef IRQ_NEST_EN
    wr(0, 32'h3F); wr(1, 32'h3F);
    irq_src = 6'h04; tick();
    irq_src = 6'h00; tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    irq_src = 6'h10; tick();
    irq_src = 6'h00;
    exp_v("t6_preempt_hw", HW, 0, 32'h10);
    tick(); check_sb();
    int_ack = 1'b1;
    exp_v("t6_nest_hw", HW, 0, 0); exp_v("t6_nest_ctrl", RD, 3, 32'h8000_00C0);
    tick(); int_ack = 1'b0; check_sb();
    exp_v("t6_pop_busy", BSY, 0, 1); exp_v("t6_pop_ctrl", RD, 3, 32'h8000_0020);
    wr(3, 0); check_sb();
    exp_v("t6_idle_busy", BSY, 0, 0); exp_v("t6_idle_ctrl", RD, 3, 32'h20);
    wr(3, 0); check_sb();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
